// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
// EX-stage issue/stall controller for RV32M divide-class instructions
// (DIV, DIVU, REM, REMU). Captures operands from ID/EX, resolves divide-by-zero
// and signed overflow locally, issues all other operations to an iterative
// divider, stalls the pipeline until the result is ready, and then presents a
// single-cycle register-file write request.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_i               divide-class instruction valid in EX
//   op1_i, op2_i        dividend / divisor
//   func3_i             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rd_addr_i           destination register
//   flush_i             pipeline flush, kills a pending op (not in DONE)
//   hold_o              pipeline stall request
//   div_en_o            one-cycle start pulse to the divider
//   div_op1_o/op2_o     registered operands to the divider
//   div_func3_o         registered func3 to the divider
//   div_quot_i/rem_i    divider results (sign-corrected)
//   div_ready_i         divider result valid pulse
//   div_busy_i          divider currently computing
//   wd_en_o/addr_o/data_o  registered single-cycle writeback request
// ---------------------------------------------------------------------------
module div_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic [2:0]  func3_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        flush_i,
   output logic        hold_o,
   output logic        div_en_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   output logic [2:0]  div_func3_o,
   input  logic [31:0] div_quot_i,
   input  logic [31:0] div_rem_i,
   input  logic        div_ready_i,
   input  logic        div_busy_i,
   output logic        wd_en_o,
   output logic [4:0]  wd_addr_o,
   output logic [31:0] wd_data_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_op1;
   logic [31:0] r_op2;
   logic [2:0]  r_func3;
   logic [4:0]  r_rd;
   logic        r_wd_en;
   logic [4:0]  r_wd_addr;
   logic [31:0] r_wd_data;

   logic        w_idle;
   logic        w_issue;
   logic        w_wait;
   logic        w_accept;
   logic        w_div_zero;
   logic        w_overflow;
   logic        w_special;
   logic [31:0] w_special_res;
   logic        w_ready_ok;
   logic        w_to_done;
   logic [31:0] w_done_data;
   logic [4:0]  w_done_rd;

   assign w_idle  = (r_state == StIdle);
   assign w_issue = (r_state == StIssue);
   assign w_wait  = (r_state == StWait);

   assign w_accept   = w_idle & req_i & ~flush_i;
   assign w_div_zero = (op2_i == 32'd0);
   // Signed overflow only for DIV/REM (func3[0]=0): -2^31 / -1.
   assign w_overflow = ~func3_i[0] & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);
   assign w_special  = w_div_zero | w_overflow;

   always_comb begin
      w_special_res = 32'd0;
      if (w_div_zero) begin
         w_special_res = func3_i[1] ? op1_i : 32'hFFFF_FFFF;
      end else begin
         w_special_res = func3_i[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // Flush wins over a simultaneous ready.
   assign w_ready_ok  = w_wait & div_ready_i & ~flush_i;
   assign w_to_done   = (w_accept & w_special) | w_ready_ok;
   assign w_done_data = w_wait ? (r_func3[1] ? div_rem_i : div_quot_i) : w_special_res;
   assign w_done_rd   = w_wait ? r_rd : rd_addr_i;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_nxt = w_special ? StDone : StIssue;
            end
         end
         StIssue: begin
            if (flush_i) begin
               w_state_nxt = StIdle;
            end else if (!div_busy_i) begin
               w_state_nxt = StWait;
            end
         end
         StWait: begin
            if (flush_i) begin
               w_state_nxt = StIdle;
            end else if (div_ready_i) begin
               w_state_nxt = StDone;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_op1     <= 32'd0;
         r_op2     <= 32'd0;
         r_func3   <= 3'd0;
         r_rd      <= 5'd0;
         r_wd_en   <= 1'b0;
         r_wd_addr <= 5'd0;
         r_wd_data <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op1   <= op1_i;
            r_op2   <= op2_i;
            r_func3 <= func3_i;
            r_rd    <= rd_addr_i;
         end
         // Write request is registered so it appears exactly in the DONE cycle.
         r_wd_en <= w_to_done & (w_done_rd != 5'd0);
         if (w_to_done) begin
            r_wd_addr <= w_done_rd;
            r_wd_data <= w_done_data;
         end
      end
   end

   // Stale divides after a flush keep the new op parked in ISSUE.
   assign div_en_o    = w_issue & ~div_busy_i & ~flush_i;
   assign hold_o      = w_accept | w_issue | w_wait;
   assign div_op1_o   = r_op1;
   assign div_op2_o   = r_op2;
   assign div_func3_o = r_func3;
   assign wd_en_o     = r_wd_en;
   assign wd_addr_o   = r_wd_addr;
   assign wd_data_o   = r_wd_data;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        req_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic [2:0]  func3_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        hold_o;
   logic        div_en_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [2:0]  div_func3_o;
   logic [31:0] div_quot_i;
   logic [31:0] div_rem_i;
   logic        div_ready_i;
   logic        div_busy_i;
   logic        wd_en_o;
   logic [4:0]  wd_addr_o;
   logic [31:0] wd_data_o;

   int errors = 0;
   int checks = 0;
   logic [36:0] exp_q[$];
   logic        prev_wd_en = 1'b0;

   div_issue_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .op1_i      (op1_i),
      .op2_i      (op2_i),
      .func3_i    (func3_i),
      .rd_addr_i  (rd_addr_i),
      .flush_i    (flush_i),
      .hold_o     (hold_o),
      .div_en_o   (div_en_o),
      .div_op1_o  (div_op1_o),
      .div_op2_o  (div_op2_o),
      .div_func3_o(div_func3_o),
      .div_quot_i (div_quot_i),
      .div_rem_i  (div_rem_i),
      .div_ready_i(div_ready_i),
      .div_busy_i (div_busy_i),
      .wd_en_o    (wd_en_o),
      .wd_addr_o  (wd_addr_o),
      .wd_data_o  (wd_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Scoreboard: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst && wd_en_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected none",
                     wd_addr_o, wd_data_o);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({wd_addr_o, wd_data_o} !== e) begin
               errors++;
               $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        wd_addr_o, wd_data_o, e[36:32], e[31:0]);
            end
         end
         checks++;
         if (prev_wd_en) begin
            errors++;
            $display("FAIL wd_en_width: got wd_en high two cycles, expected one");
         end
      end
      prev_wd_en = wd_en_o;
   end

   // Reference divider: RISC-V semantics for non-special operands.
   function automatic void div_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] f, output logic [31:0] q,
                                     output logic [31:0] r);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (f[0]) begin
         q = a / b;
         r = a % b;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                            input logic [4:0] rd);
      req_i = 1'b1; op1_i = a; op2_i = b; func3_i = f; rd_addr_i = rd;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_i = 0; flush_i = 0; op1_i = 0; op2_i = 0; func3_i = 0; rd_addr_i = 0;
      div_quot_i = 0; div_rem_i = 0; div_ready_i = 0; div_busy_i = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({hold_o, div_en_o, wd_en_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: got hold/en/wd_en=%b, expected 000",
                  {hold_o, div_en_o, wd_en_o});
      end
      checks++;
      if ({div_op1_o, div_op2_o, div_func3_o, wd_addr_o, wd_data_o} !== 104'd0) begin
         errors++;
         $display("FAIL reset_data: got op1=%h op2=%h f3=%b addr=%0d data=%h, expected 0",
                  div_op1_o, div_op2_o, div_func3_o, wd_addr_o, wd_data_o);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Normal path; ready arrives lat cycles after the div_en_o cycle.
   task automatic run_normal(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f, input logic [4:0] rd, input int lat);
      logic [31:0] q, r, exp;
      int bad_en, bad_hold, bad_op;
      bad_en = 0; bad_hold = 0; bad_op = 0;
      div_model(a, b, f, q, r);
      exp = f[1] ? r : q;
      @(negedge clk);
      drive_req(a, b, f, rd);
      #1;
      checks++;
      if ({hold_o, div_en_o} !== 2'b10) begin
         errors++;
         $display("FAIL %s_capture: got hold/en=%b, expected 10", nm, {hold_o, div_en_o});
      end
      if (rd != 5'd0) exp_q.push_back({rd, exp});
      @(negedge clk);
      req_i = 1'b0; op1_i = $urandom; op2_i = $urandom;
      #1;
      checks++;
      if ({hold_o, div_en_o} !== 2'b11) begin
         errors++;
         $display("FAIL %s_issue: got hold/en=%b, expected 11", nm, {hold_o, div_en_o});
      end
      checks++;
      if ({div_op1_o, div_op2_o, div_func3_o} !== {a, b, f}) begin
         errors++;
         $display("FAIL %s_ops: got %h %h %b, expected %h %h %b", nm, div_op1_o, div_op2_o,
                  div_func3_o, a, b, f);
      end
      for (int i = 2; i <= lat; i++) begin
         @(negedge clk);
         div_busy_i = 1'b1;
         #1;
         if (div_en_o !== 1'b0) bad_en++;
         if (hold_o !== 1'b1) bad_hold++;
         if ({div_op1_o, div_op2_o, div_func3_o} !== {a, b, f}) bad_op++;
      end
      checks++;
      if (bad_en != 0 || bad_hold != 0 || bad_op != 0) begin
         errors++;
         $display("FAIL %s_wait: got en_err=%0d hold_err=%0d op_err=%0d, expected 0 0 0",
                  nm, bad_en, bad_hold, bad_op);
      end
      @(negedge clk);
      div_ready_i = 1'b1; div_quot_i = q; div_rem_i = r; div_busy_i = 1'b0;
      #1;
      checks++;
      if (hold_o !== 1'b1) begin
         errors++;
         $display("FAIL %s_hold_ready: got %b, expected 1", nm, hold_o);
      end
      @(negedge clk);
      div_ready_i = 1'b0; div_quot_i = $urandom; div_rem_i = $urandom;
      #1;
      checks++;
      if ({wd_en_o, hold_o} !== {rd != 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL %s_done: got wd_en/hold=%b, expected %b", nm, {wd_en_o, hold_o},
                  {rd != 5'd0, 1'b0});
      end
      if (rd != 5'd0) begin
         checks++;
         if ({wd_addr_o, wd_data_o} !== {rd, exp}) begin
            errors++;
            $display("FAIL %s_wd: got addr=%0d data=%h, expected addr=%0d data=%h", nm,
                     wd_addr_o, wd_data_o, rd, exp);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (wd_en_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_wd_clear: got %b, expected 0", nm, wd_en_o);
      end
   endtask

   task automatic run_special(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f, input logic [4:0] rd,
                              input logic [31:0] exp);
      @(negedge clk);
      drive_req(a, b, f, rd);
      #1;
      checks++;
      if ({hold_o, div_en_o} !== 2'b10) begin
         errors++;
         $display("FAIL %s_capture: got hold/en=%b, expected 10", nm, {hold_o, div_en_o});
      end
      exp_q.push_back({rd, exp});
      @(negedge clk);
      #1;
      checks++;
      if ({wd_en_o, hold_o, div_en_o, wd_addr_o, wd_data_o} !== {3'b100, rd, exp}) begin
         errors++;
         $display("FAIL %s_done: got en/hold/div_en=%b addr=%0d data=%h, expected 100 %0d %h",
                  nm, {wd_en_o, hold_o, div_en_o}, wd_addr_o, wd_data_o, rd, exp);
      end
      req_i = 1'b0;
   endtask

   task automatic test_divu();
      run_normal("divu", 32'd100, 32'd7, 3'b101, 5'd5, 34);
   endtask

   task automatic test_rem();
      run_normal("rem", 32'hFFFF_FF9C, 32'd7, 3'b110, 5'd12, 9);
   endtask

   task automatic test_special();
      run_special("div0", 32'd55, 32'd0, 3'b100, 5'd3, 32'hFFFF_FFFF);
      run_special("remu0", 32'h1234, 32'd0, 3'b111, 5'd4, 32'h1234);
      run_special("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 5'd6, 32'h8000_0000);
      run_special("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 5'd7, 32'd0);
      // Unsigned forms of the overflow operands are ordinary divides.
      run_normal("divu_big", 32'h8000_0000, 32'hFFFF_FFFF, 3'b101, 5'd8, 3);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive_req(32'd9, 32'd0, 3'b101, 5'd10);
      exp_q.push_back({5'd10, 32'hFFFF_FFFF});
      // DONE cycle: same instruction still presented, must not be re-accepted.
      @(negedge clk);
      #1;
      checks++;
      if ({wd_en_o, hold_o} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_done: got wd_en/hold=%b, expected 10", {wd_en_o, hold_o});
      end
      @(negedge clk);
      drive_req(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 5'd11);
      exp_q.push_back({5'd11, 32'd0});
      #1;
      checks++;
      if (hold_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_hold: got %b, expected 1", hold_o);
      end
      @(negedge clk);
      req_i = 1'b0;
      #1;
      checks++;
      if ({wd_en_o, wd_addr_o} !== {1'b1, 5'd11}) begin
         errors++;
         $display("FAIL b2b_second_wd: got en=%b addr=%0d, expected 1 11", wd_en_o, wd_addr_o);
      end
   endtask

   task automatic test_flush();
      // Flush in WAIT, then a new op while the stale divide still runs.
      @(negedge clk);
      drive_req(32'd50, 32'd5, 3'b101, 5'd3);
      @(negedge clk);
      req_i = 1'b0;
      @(negedge clk);
      div_busy_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      checks++;
      if ({hold_o, wd_en_o} !== 2'b00) begin
         errors++;
         $display("FAIL flush_drop: got hold/wd_en=%b, expected 00", {hold_o, wd_en_o});
      end
      drive_req(32'd81, 32'd9, 3'b101, 5'd7);
      exp_q.push_back({5'd7, 32'd9});
      @(negedge clk);
      req_i = 1'b0;
      #1;
      checks++;
      if ({hold_o, div_en_o} !== 2'b10) begin
         errors++;
         $display("FAIL flush_park: got hold/en=%b, expected 10", {hold_o, div_en_o});
      end
      @(negedge clk);
      div_ready_i = 1'b1; div_quot_i = 32'd10; div_rem_i = 32'd0;
      @(negedge clk);
      div_ready_i = 1'b0; div_busy_i = 1'b0;
      #1;
      checks++;
      if ({wd_en_o, div_en_o, hold_o} !== 3'b011) begin
         errors++;
         $display("FAIL flush_late_ready: got wd_en/en/hold=%b, expected 011",
                  {wd_en_o, div_en_o, hold_o});
      end
      @(negedge clk);
      div_busy_i = 1'b1;
      repeat (3) @(negedge clk);
      div_ready_i = 1'b1; div_quot_i = 32'd9; div_rem_i = 32'd0; div_busy_i = 1'b0;
      @(negedge clk);
      div_ready_i = 1'b0;
      #1;
      checks++;
      if ({wd_en_o, wd_addr_o, wd_data_o} !== {1'b1, 5'd7, 32'd9}) begin
         errors++;
         $display("FAIL flush_second_wd: got en=%b addr=%0d data=%h, expected 1 7 9",
                  wd_en_o, wd_addr_o, wd_data_o);
      end
      // Flush coincident with ready in WAIT: flush wins.
      @(negedge clk);
      drive_req(32'd20, 32'd4, 3'b100, 5'd9);
      @(negedge clk);
      req_i = 1'b0;
      @(negedge clk);
      div_ready_i = 1'b1; div_quot_i = 32'd5; flush_i = 1'b1;
      @(negedge clk);
      div_ready_i = 1'b0; flush_i = 1'b0;
      #1;
      checks++;
      if ({wd_en_o, hold_o} !== 2'b00) begin
         errors++;
         $display("FAIL flush_vs_ready: got wd_en/hold=%b, expected 00", {wd_en_o, hold_o});
      end
   endtask

   task automatic test_rd0_reset();
      run_normal("rd0", 32'd77, 32'd8, 3'b101, 5'd0, 4);
      @(negedge clk);
      drive_req(32'd200, 32'd3, 3'b101, 5'd9);
      @(negedge clk);
      req_i = 1'b0;
      @(negedge clk);
      div_busy_i = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({hold_o, div_en_o, wd_en_o, div_op1_o, div_op2_o, div_func3_o, wd_addr_o,
           wd_data_o} !== 107'd0) begin
         errors++;
         $display("FAIL reset_midop: got hold=%b en=%b wd_en=%b op1=%h f3=%b, expected 0",
                  hold_o, div_en_o, wd_en_o, div_op1_o, div_func3_o);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      div_ready_i = 1'b1; div_quot_i = 32'd66; div_busy_i = 1'b0;
      @(negedge clk);
      div_ready_i = 1'b0;
      #1;
      checks++;
      if ({wd_en_o, hold_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_late_ready: got wd_en/hold=%b, expected 00", {wd_en_o, hold_o});
      end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_rem();
      test_special();
      test_back_to_back();
      test_flush();
      test_rd0_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending writes, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

EX-stage issue/stall controller for RV32M divide-class instructions (DIV, DIVU, REM, REMU). It sits between the ID/EX pipeline register and the iterative divider. It captures the operands, resolves the architectural special cases locally, issues all other operations to the divider, and stalls the pipeline until a result is ready. It then presents a single-cycle register-file write request to writeback.

## Interface
Parameters:
- none; datapath fixed at 32 bits, register address 5 bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_i  in  1  divide-class instruction valid in EX this cycle
- op1_i  in  32  rs1 value (dividend)
- op2_i  in  32  rs2 value (divisor)
- func3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- rd_addr_i  in  5  destination register
- flush_i  in  1  pipeline flush (taken jump/branch); kills the pending op
- hold_o  out  1  pipeline stall request
- div_en_o  out  1  one-cycle start pulse to the divider
- div_op1_o  out  32  registered dividend to the divider
- div_op2_o  out  32  registered divisor to the divider
- div_func3_o  out  3  registered func3 to the divider
- div_quot_i  in  32  divider quotient, sign-corrected
- div_rem_i  in  32  divider remainder, sign-corrected
- div_ready_i  in  1  divider result valid, single-cycle pulse
- div_busy_i  in  1  divider currently computing
- wd_en_o  out  1  register write enable, one cycle
- wd_addr_o  out  5  register write address
- wd_data_o  out  32  register write data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **IDLE, req_i=1, flush_i=0:** latch op1, op2, func3 and rd into the div_* and internal registers.
  - op2==0: result = 0xFFFFFFFF for DIV/DIVU, op1 for REM/REMU. Go to DONE.
  - func3=DIV/REM, op1==0x80000000, op2==0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM. Go to DONE.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - If div_busy_i=1 (a stale divide is still running after a flush), stay in ISSUE.
  - Else assert div_en_o for exactly one cycle and go to WAIT.
- **WAIT:** on div_ready_i, latch div_quot_i when func3[1]=0, or div_rem_i when func3[1]=1, into the result register. Go to DONE.
- **DONE:** wd_en_o=1 unless rd==0. Present wd_addr_o=rd and wd_data_o=result. Next state is IDLE.
- hold_o = (IDLE & req_i & ~flush_i) | ISSUE | WAIT. hold_o is 0 in DONE, so the pipeline advances on that cycle.
- req_i is ignored outside IDLE. During the DONE cycle it is still the same held instruction.
- **Flush:** flush_i in ISSUE or WAIT returns the FSM to IDLE immediately, with no writeback and hold_o dropping the next cycle.
  - A div_ready_i arriving later is discarded.
  - flush_i together with div_ready_i in WAIT: the flush wins.
  - flush_i in DONE is ignored, because the write commits.
- div_op1_o, div_op2_o and div_func3_o stay stable from capture until the FSM leaves WAIT.
- **Reset:** asynchronous. FSM goes to IDLE and every output and internal register goes to 0, including mid-operation. A divider result arriving after reset is ignored.

## Timing
- Reset values: hold_o=0, div_en_o=0, div_op1_o=0, div_op2_o=0, div_func3_o=0, wd_en_o=0, wd_addr_o=0, wd_data_o=0.
- **Special case:** req_i at cycle 0 gives hold_o=1 in cycle 0 (combinational) and DONE in cycle 1 with wd_en_o=1. Total stall is 1 cycle.
- **Normal path:** capture at cycle 0, div_en_o=1 in cycle 1 (divider idle), WAIT from cycle 2. If div_ready_i arrives at cycle N, DONE and wd_en_o=1 occur at cycle N+1. hold_o is high for cycles 0..N.
- Back-to-back divides: the second req_i is accepted in the cycle after DONE, at the earliest.
- wd_* outputs are registered. wd_en_o never stays high for more than one cycle.

## Test plan
- **DIVU:** op1=100, op2=7, rd=5, divider ready 34 cycles after issue -> one div_en_o pulse; wd_en_o=1, wd_addr_o=5, wd_data_o=14; hold_o falls in the DONE cycle.
- **REM:** op1=0xFFFFFF9C (-100), op2=7, model returns rem=0xFFFFFFFE -> wd_data_o=0xFFFFFFFE; div_func3_o=110 held throughout.
- **Divide by zero:** DIV with op2=0 -> no div_en_o, wd_data_o=0xFFFFFFFF one cycle later. REMU with op1=0x1234, op2=0 -> wd_data_o=0x1234.
- **Signed overflow:** DIV with 0x80000000 / 0xFFFFFFFF -> wd_data_o=0x80000000. REM with the same operands -> wd_data_o=0. Both without issuing.
- **Flush in WAIT:** followed by a new DIVU while div_busy_i is still 1 -> no writeback for the first op; the second op waits in ISSUE until div_busy_i=0, and the late first div_ready_i is ignored.
- **rd=0 and reset:** DIVU with rd=0 -> wd_en_o stays 0. rst asserted low in WAIT -> all outputs 0 immediately, and a following div_ready_i produces no write.
